// File: rtl/core_comm_pkg.sv
// Shared commit-side trap types and helpers.
// Provides:
//   mstatusOp_t  - mstatus side effect requested alongside a redirect
//   trapKind_t   - what kind of event the trap controller accepted
//   INT_PRIO     - interrupt codes in descending service priority
//   mcause_enc   - mcause value for a given kind/code
//   trap_target  - redirect target derived from mtvec
package core_comm_pkg;

  typedef enum logic [1:0] {
    MST_NONE = 2'd0,  // no mstatus change
    MST_TRAP = 2'd1,  // MPIE <= MIE, MIE <= 0
    MST_MRET = 2'd2   // MIE <= MPIE, MPIE <= 1
  } mstatusOp_t;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_MRET = 2'd1,
    KIND_INT  = 2'd2
  } trapKind_t;

  localparam int CAUSE_W    = 16;
  localparam int N_INT_PRIO = 6;

  // mExter > mSoft > mTimer > sExter > sSoft > sTimer
  localparam int INT_PRIO [N_INT_PRIO] = '{11, 3, 7, 9, 1, 5};

  // Interrupts carry the MSB flag; exception codes (known or not) pass through.
  function automatic logic [63:0] mcause_enc(input trapKind_t kind,
                                             input logic [CAUSE_W-1:0] code);
    logic [63:0] v;
    v = {{(64-CAUSE_W){1'b0}}, code};
    if (kind == KIND_INT) v[63] = 1'b1;
    return v;
  endfunction

  // Vectored mode only applies to interrupts; everything else lands on base.
  function automatic logic [63:0] trap_target(input logic [63:0] mtvec,
                                              input trapKind_t kind,
                                              input logic [CAUSE_W-1:0] code);
    logic [63:0] base;
    base = {mtvec[63:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && kind == KIND_INT)
      return base + {{(62-CAUSE_W){1'b0}}, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_int_arbiter.sv
// Fixed-priority selection of the pending machine/supervisor interrupt.
// Ports:
//   i_int_pending  - mip & mie, bit n = interrupt code n
//   i_mstatus_mie  - global M-mode interrupt enable
//   o_vld          - an enabled, recognised interrupt is pending
//   o_cause        - code of the winning interrupt (0 when !o_vld)
// Pending bits outside the six standard codes never win.
module trap_int_arbiter
  import core_comm_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic [INT_W-1:0]   i_int_pending,
  input  logic               i_mstatus_mie,
  output logic               o_vld,
  output logic [CAUSE_W-1:0] o_cause
);

  // Widen so code 11 is always addressable even for a narrow vector.
  localparam int PW = (INT_W > 12) ? INT_W : 12;

  logic [PW-1:0] w_pend;
  assign w_pend = PW'(i_int_pending);

  // Walk lowest priority first so the highest-priority hit is the last write.
  always_comb begin
    o_vld   = 1'b0;
    o_cause = '0;
    for (int k = N_INT_PRIO - 1; k >= 0; k--) begin
      if (i_mstatus_mie && (((w_pend >> INT_PRIO[k]) & PW'(1)) != '0)) begin
        o_vld   = 1'b1;
        o_cause = CAUSE_W'(INT_PRIO[k]);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer: accepts the oldest exception, an mret, or an
// enabled interrupt, flushes the backend, then updates CSRs and redirects
// fetch to the trap vector (or mepc for mret).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   i_exc_*                  - exception from the oldest committing inst
//   i_mret_vld               - oldest committing inst is mret
//   i_commit_vld/pc          - instruction boundary available for interrupts
//   i_int_pending, i_mstatus_mie, i_mtvec, i_mepc - CSR state
//   i_flush_done             - backend drained
//   o_int_take               - interrupt accepted this cycle (blocks commit)
//   o_trap_busy              - sequence in flight, commit stalls
//   o_flush                  - one-cycle flush pulse
//   o_csr_we, o_mepc, o_mcause, o_mtval, o_mstatus_op - CSR update
//   o_redirect_vld/pc        - fetch redirect
//
// state      | meaning
// S_IDLE     | waiting for exception / mret / interrupt
// S_FLUSH    | flush pulse issued this cycle
// S_WAIT     | waiting for the backend to drain
// S_REDIRECT | CSR update + fetch redirect, one cycle
module trap_ctrl
  import core_comm_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_exc_vld,
  input  logic [15:0]      i_exc_cause,
  input  logic [63:0]      i_exc_epc,
  input  logic [63:0]      i_exc_tval,
  input  logic             i_mret_vld,
  input  logic             i_commit_vld,
  input  logic [63:0]      i_commit_pc,
  input  logic [INT_W-1:0] i_int_pending,
  input  logic             i_mstatus_mie,
  input  logic [63:0]      i_mtvec,
  input  logic [63:0]      i_mepc,
  input  logic             i_flush_done,
  output logic             o_int_take,
  output logic             o_trap_busy,
  output logic             o_flush,
  output logic             o_csr_we,
  output logic [63:0]      o_mepc,
  output logic [63:0]      o_mcause,
  output logic [63:0]      o_mtval,
  output logic [1:0]       o_mstatus_op,
  output logic             o_redirect_vld,
  output logic [63:0]      o_redirect_pc
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT, S_REDIRECT} state_t;

  state_t             r_state, w_state_nxt;
  trapKind_t          r_kind;
  logic [CAUSE_W-1:0] r_cause;
  logic [63:0]        r_epc;    // mepc to write, or mret target
  logic [63:0]        r_tval;
  logic [63:0]        r_mtvec;

  logic               w_int_vld;
  logic [CAUSE_W-1:0] w_int_cause;
  logic               w_idle, w_int_cond, w_accept;

  trap_int_arbiter #(.INT_W(INT_W)) u_arb (
    .i_int_pending (i_int_pending),
    .i_mstatus_mie (i_mstatus_mie),
    .o_vld         (w_int_vld),
    .o_cause       (w_int_cause)
  );

  assign w_idle     = (r_state == S_IDLE);
  assign w_int_cond = w_int_vld && i_commit_vld;
  assign w_accept   = w_idle && (i_exc_vld || i_mret_vld || w_int_cond);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kind  <= KIND_EXC;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
      r_mtvec <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mtvec <= i_mtvec;
        if (i_exc_vld) begin
          r_kind  <= KIND_EXC;
          r_cause <= i_exc_cause;
          r_epc   <= i_exc_epc;
          r_tval  <= i_exc_tval;
        end else if (i_mret_vld) begin
          r_kind  <= KIND_MRET;
          r_cause <= '0;
          r_epc   <= i_mepc;
          r_tval  <= '0;
        end else begin
          r_kind  <= KIND_INT;
          r_cause <= w_int_cause;
          r_epc   <= i_commit_pc;
          r_tval  <= '0;
        end
      end
    end
  end

  // Outputs are forced low while rst is asserted so a reset landing in
  // S_REDIRECT cannot leak a CSR write or redirect.
  always_comb begin
    w_state_nxt    = r_state;
    o_int_take     = 1'b0;
    o_trap_busy    = 1'b0;
    o_flush        = 1'b0;
    o_csr_we       = 1'b0;
    o_mepc         = '0;
    o_mcause       = '0;
    o_mtval        = '0;
    o_mstatus_op   = MST_NONE;
    o_redirect_vld = 1'b0;
    o_redirect_pc  = '0;
    if (!rst) begin
      o_trap_busy = !w_idle;
      o_int_take  = w_idle && w_int_cond && !i_exc_vld && !i_mret_vld;
      case (r_state)
        S_IDLE: begin
          if (w_accept) w_state_nxt = S_FLUSH;
        end
        S_FLUSH: begin
          o_flush     = 1'b1;
          w_state_nxt = i_flush_done ? S_REDIRECT : S_WAIT;
        end
        S_WAIT: begin
          if (i_flush_done) w_state_nxt = S_REDIRECT;
        end
        S_REDIRECT: begin
          o_redirect_vld = 1'b1;
          w_state_nxt    = S_IDLE;
          if (r_kind == KIND_MRET) begin
            o_mstatus_op  = MST_MRET;
            o_redirect_pc = r_epc;
          end else begin
            o_csr_we      = 1'b1;
            o_mstatus_op  = MST_TRAP;
            o_mepc        = r_epc;
            o_mcause      = mcause_enc(r_kind, r_cause);
            o_mtval       = r_tval;
            o_redirect_pc = trap_target(r_mtvec, r_kind, r_cause);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk, rst;
  logic        i_exc_vld, i_mret_vld, i_commit_vld, i_mstatus_mie, i_flush_done;
  logic [15:0] i_exc_cause, i_int_pending;
  logic [63:0] i_exc_epc, i_exc_tval, i_commit_pc, i_mtvec, i_mepc;
  logic        o_int_take, o_trap_busy, o_flush, o_csr_we, o_redirect_vld;
  logic [63:0] o_mepc, o_mcause, o_mtval, o_redirect_pc;
  logic [1:0]  o_mstatus_op;

  trap_ctrl #(.INT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_exc_vld(i_exc_vld), .i_exc_cause(i_exc_cause), .i_exc_epc(i_exc_epc),
    .i_exc_tval(i_exc_tval), .i_mret_vld(i_mret_vld), .i_commit_vld(i_commit_vld),
    .i_commit_pc(i_commit_pc), .i_int_pending(i_int_pending),
    .i_mstatus_mie(i_mstatus_mie), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .i_flush_done(i_flush_done), .o_int_take(o_int_take), .o_trap_busy(o_trap_busy),
    .o_flush(o_flush), .o_csr_we(o_csr_we), .o_mepc(o_mepc), .o_mcause(o_mcause),
    .o_mtval(o_mtval), .o_mstatus_op(o_mstatus_op), .o_redirect_vld(o_redirect_vld),
    .o_redirect_pc(o_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc, mepc, mcause, mtval;
    logic [1:0]  op;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks, errors, n_acc, n_flush, fd_mode;
  localparam int PRIO [6] = '{11, 3, 7, 9, 1, 5};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a trap unit should do with the current IDLE inputs.
  function automatic bit model(output exp_t e, output bit int_take);
    int sel;
    logic [63:0] base;
    sel = -1;
    e = '{default: '0};
    int_take = 1'b0;
    base = i_mtvec & ~64'd3;
    for (int k = 0; k < 6; k++)
      if (sel < 0 && ((i_int_pending >> PRIO[k]) & 16'd1) != 16'd0) sel = PRIO[k];
    if (i_exc_vld) begin
      e.pc = base; e.mepc = i_exc_epc; e.mcause = 64'(i_exc_cause);
      e.mtval = i_exc_tval; e.op = 2'd1; e.we = 1'b1;
      return 1'b1;
    end
    if (i_mret_vld) begin
      e.pc = i_mepc; e.op = 2'd2; e.we = 1'b0;
      return 1'b1;
    end
    if (i_mstatus_mie && i_commit_vld && sel >= 0) begin
      int_take = 1'b1;
      e.mcause = 64'h8000_0000_0000_0000 + 64'(sel);
      e.pc = base + ((i_mtvec[1:0] == 2'd1) ? 64'(sel) * 64'd4 : 64'd0);
      e.mepc = i_commit_pc; e.mtval = '0; e.op = 2'd1; e.we = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    i_exc_vld = 0; i_mret_vld = 0; i_commit_vld = 0; i_mstatus_mie = 0;
    i_exc_cause = '0; i_int_pending = '0; i_exc_epc = '0; i_exc_tval = '0;
    i_commit_pc = '0; i_mtvec = '0; i_mepc = '0;
  endtask

  // Called at a negedge with inputs set; returns #1 after the accept edge.
  task automatic issue(input string tag);
    exp_t e;
    bit   it, acc;
    #1;
    acc = model(e, it);
    chk({tag, "_int_take"}, 64'(o_int_take), 64'(it));
    if (acc) begin
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    i_exc_vld = 0; i_mret_vld = 0; i_commit_vld = 0;
  endtask

  task automatic wait_idle(input bit junk);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_trap_busy && junk) begin
        i_exc_vld = 1'($urandom); i_mret_vld = 1'($urandom);
        i_commit_vld = 1'($urandom); i_mstatus_mie = 1'($urandom);
        i_int_pending = 16'($urandom); i_mtvec = {$urandom, $urandom};
        i_mepc = {$urandom, $urandom}; i_exc_epc = {$urandom, $urandom};
      end
    end while (o_trap_busy && n < 100);
    if (o_trap_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout busy=%0b required=0", o_trap_busy);
    end
    i_exc_vld = 0; i_mret_vld = 0; i_commit_vld = 0;
  endtask

  initial begin
    checks = 0; errors = 0; n_acc = 0; n_flush = 0; fd_mode = 0;
    rst = 1'b1; i_flush_done = 1'b1;
    clear_inputs();

    fork
      forever begin
        @(negedge clk);
        if (fd_mode == 1) i_flush_done = ($urandom_range(0, 2) == 0);
      end
      forever begin
        @(negedge clk);
        if (o_flush) n_flush++;
        if (o_redirect_vld) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_redirect pc=%h required=none", o_redirect_pc);
          end else begin
            m_e = sb.pop_front();
            chk("redirect_pc", o_redirect_pc, m_e.pc);
            chk("mstatus_op", 64'(o_mstatus_op), 64'(m_e.op));
            chk("csr_we", 64'(o_csr_we), 64'(m_e.we));
            if (m_e.we) begin
              chk("mepc", o_mepc, m_e.mepc);
              chk("mcause", o_mcause, m_e.mcause);
              chk("mtval", o_mtval, m_e.mtval);
            end
          end
        end else if (o_csr_we) begin
          checks++; errors++;
          $display("FAIL stray_csr_we actual=1 required=0");
        end
      end
    join_none

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(o_trap_busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(o_trap_busy), 0);
    chk("reset_flush", 64'(o_flush), 0);
    chk("reset_redirect", 64'(o_redirect_vld), 0);

    // Exception, flush_done tied high: minimum latency
    i_exc_vld = 1; i_exc_cause = 16'd2; i_exc_epc = 64'h8000_0000_0000_0040;
    i_exc_tval = 64'h13; i_mtvec = 64'h8000_0000_0000_0100;
    issue("exc");
    @(negedge clk);
    chk("exc_flush_t1", 64'(o_flush), 1);
    chk("exc_busy_t1", 64'(o_trap_busy), 1);
    @(negedge clk);
    chk("exc_redirect_t2", 64'(o_redirect_vld), 1);
    chk("exc_flush_t2", 64'(o_flush), 0);
    @(negedge clk);
    chk("exc_idle_t3", 64'(o_trap_busy), 0);
    chk("exc_redirect_t3", 64'(o_redirect_vld), 0);

    // Vectored interrupt
    clear_inputs();
    i_mtvec = 64'h8000_0000_0000_0001; i_int_pending = 16'h0080;
    i_mstatus_mie = 1; i_commit_vld = 1; i_commit_pc = 64'h8000_0000_0000_0080;
    issue("vec_int");
    wait_idle(0);

    // Exception beats pending interrupts; interrupt retaken afterwards
    clear_inputs();
    i_mtvec = 64'h8000_0000_0000_0100; i_int_pending = 16'h0888;
    i_mstatus_mie = 1; i_commit_vld = 1; i_commit_pc = 64'h8000_0000_0000_0300;
    i_exc_vld = 1; i_exc_cause = 16'd5; i_exc_epc = 64'h8000_0000_0000_0044;
    issue("prio_exc");
    wait_idle(0);
    i_commit_vld = 1;
    issue("prio_int");
    wait_idle(0);

    // mret with flush_done delayed 4 cycles
    clear_inputs();
    fd_mode = 2; i_flush_done = 0;
    i_mret_vld = 1; i_mepc = 64'h8000_0000_0000_0200;
    issue("mret");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("mret_busy_wait", 64'(o_trap_busy), 1);
      chk("mret_no_redirect_yet", 64'(o_redirect_vld), 0);
      if (k == 4) i_flush_done = 1;
    end
    @(negedge clk);
    chk("mret_redirect", 64'(o_redirect_vld), 1);
    @(negedge clk);
    chk("mret_redirect_once", 64'(o_redirect_vld), 0);
    chk("mret_idle", 64'(o_trap_busy), 0);

    // Masked interrupt
    clear_inputs();
    fd_mode = 0; i_flush_done = 1;
    i_int_pending = 16'h0800; i_mstatus_mie = 0; i_commit_vld = 1;
    issue("masked");
    i_commit_vld = 1;
    repeat (2) begin
      @(negedge clk);
      chk("masked_busy", 64'(o_trap_busy), 0);
      chk("masked_flush", 64'(o_flush), 0);
    end

    // Reset while waiting for the drain
    clear_inputs();
    @(negedge clk);
    fd_mode = 2; i_flush_done = 0;
    i_exc_vld = 1; i_exc_cause = 16'd7; i_mtvec = 64'h8000_0000_0000_0100;
    issue("rst_wait");
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait_busy", 64'(o_trap_busy), 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    @(negedge clk);
    chk("rst_wait_idle", 64'(o_trap_busy), 0);
    i_flush_done = 1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_wait_no_redirect", 64'(o_redirect_vld), 0);
      chk("rst_wait_no_csr", 64'(o_csr_we), 0);
    end

    // Randomized events against the model
    fd_mode = 1;
    for (int n = 0; n < 300; n++) begin
      clear_inputs();
      i_exc_vld = ($urandom_range(0, 3) == 0);
      i_mret_vld = ($urandom_range(0, 3) == 0);
      i_commit_vld = ($urandom_range(0, 3) != 0);
      i_mstatus_mie = ($urandom_range(0, 3) != 0);
      i_int_pending = 16'($urandom) & 16'h0AAA;
      i_exc_cause = 16'($urandom);
      i_exc_epc = {$urandom, $urandom}; i_exc_tval = {$urandom, $urandom};
      i_commit_pc = {$urandom, $urandom}; i_mepc = {$urandom, $urandom};
      i_mtvec = {$urandom, $urandom};
      issue("rnd");
      wait_idle(1);
    end
    fd_mode = 0; i_flush_done = 1;
    repeat (3) @(negedge clk);

    chk("flush_count", 64'(n_flush), 64'(n_acc));
    chk("sb_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Commit-side consumer of the rv_trap_t exception/interrupt encodings.
- Takes the oldest committing instruction's exception, an mret request, or a pending enabled interrupt.
- Sequences pipeline flush, mepc/mcause/mtval/mstatus update, and frontend redirect to the trap vector or mepc.
- Sits between ROB commit and the CSR file and fetch redirect.

Parameters:
INT_W, 16, width of the interrupt-pending vector (bit n = rv_trap_t::interrupt code n)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
i_exc_vld  in  1  oldest committing inst raises exception (consumed this cycle)
i_exc_cause  in  16  rv_trap_t::exception code
i_exc_epc  in  64  pc of the faulting inst
i_exc_tval  in  64  trap value
i_mret_vld  in  1  oldest committing inst is mret
i_commit_vld  in  1  an instruction boundary is available this cycle
i_commit_pc  in  64  pc of the next inst to commit
i_int_pending  in  INT_W  mip & mie
i_mstatus_mie  in  1  global M interrupt enable
i_mtvec  in  64  mtvec CSR
i_mepc  in  64  mepc CSR
i_flush_done  in  1  backend drained
o_int_take  out  1  comb.; blocks commit of i_commit_pc this cycle
o_trap_busy  out  1  state != IDLE; commit stalls
o_flush  out  1  one-cycle flush pulse
o_csr_we  out  1  write mepc/mcause/mtval
o_mepc, o_mcause, o_mtval  out  64 each  CSR write data
o_mstatus_op  out  2  0 none; 1 trap entry (MPIE<=MIE, MIE<=0); 2 mret (MIE<=MPIE, MPIE<=1)
o_redirect_vld  out  1  fetch redirect
o_redirect_pc  out  64  redirect target

Behaviour:
- Reset: state IDLE; all outputs 0; latches cleared. Reset mid-sequence aborts it immediately: no CSR write, no redirect.
- FSM states: IDLE, FLUSH, WAIT, REDIRECT.
- IDLE accept priority: exception > mret > interrupt.
  - Interrupt is taken only if i_mstatus_mie && i_commit_vld && |i_int_pending.
  - o_int_take = that condition && !i_exc_vld && !i_mret_vld.
- Interrupt selection order: mExter(11) > mSoft(3) > mTimer(7) > sExter(9) > sSoft(1) > sTimer(5). Other set bits are ignored.
- On accept, latch kind (exc/mret/int), cause, and epc:
  - exc: i_exc_epc.
  - int: i_commit_pc.
  - mret: capture i_mepc into the target latch.
- Accept transitions to FLUSH. Inputs are ignored while not in IDLE.
- FLUSH: o_flush=1 for exactly this cycle. If i_flush_done=1 go to REDIRECT, else go to WAIT.
- WAIT: hold until i_flush_done=1, then go to REDIRECT.
- REDIRECT (one cycle), then IDLE:
  - o_redirect_vld=1.
  - exc/int: o_csr_we=1, o_mstatus_op=1.
  - mret: o_csr_we=0, o_mstatus_op=2, o_redirect_pc = latched mepc.
- mcause:
  - exc: zero-extended 16-bit code.
  - int: bit63=1 | code.
  - Unknown exception codes pass through unchanged.
- mtval: exc = latched tval; int = 0.
- Redirect pc:
  - base = {mtvec[63:2], 2'b00}.
  - mtvec[1:0]==1 and kind==int: base + (cause<<2).
  - Otherwise (modes 0, 2, 3, or exception): base. Addition is modulo 2^64.
- Minimum latency: accept at T, FLUSH at T+1, REDIRECT at T+2, IDLE at T+3. Next accept is possible at T+3.
- Simultaneous events:
  - exc + int: the exception wins; the interrupt stays pending and is retaken later.
  - exc + mret: exc wins.
  - i_flush_done outside FLUSH/WAIT is ignored.

Decomposition:
- Add to core_comm package: mstatusOp_t enum (NONE, TRAP, MRET) and trapKind_t enum (EXC, MRET, INT).
- The FSM state enum stays local.
- Sub-module: trap_int_arbiter. Purely combinational: i_int_pending + i_mstatus_mie to valid + 16-bit cause.

Test Plan:
- Exception: i_exc_vld, cause=2, epc=0x8000_0000_0000_0040, tval=0x13, mtvec=0x8000_0000_0000_0100, flush_done tied 1.
  -> o_flush at T+1; at T+2: redirect 0x8000_0000_0000_0100, mepc=0x...40, mcause=2, mtval=0x13, mstatus_op=1.
- Vectored interrupt: mtvec=0x8000_0000_0000_0001, pending bit7, mie=1, commit_pc=0x...80.
  -> o_int_take=1; at T+2: redirect 0x8000_0000_0000_001C, mcause=0x8000_0000_0000_0007, mtval=0.
- Priority: pending bits 3, 7, 11 set with i_exc_vld cause=5.
  -> exception taken (mcause=5). After return to IDLE, interrupt taken with mcause=0x8000_0000_0000_000B.
- mret: i_mret_vld, mepc=0x8000_0000_0000_0200, flush_done delayed 4 cycles.
  -> o_trap_busy held through WAIT; redirect 0x...200 exactly once, mstatus_op=2, o_csr_we=0.
- Masked and reset cases:
  - mie=0 with pending bit 11 -> o_int_take stays 0, no flush.
  - rst in WAIT -> next cycle IDLE; no redirect and no CSR write ever observed.
